// File: rtl/srl_pkg.sv
// Shared types, widths and the reference shift rule for the shared SRL datapath.
package srl_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = $clog2(DATA_W);

  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_e;
  typedef enum logic {OWN_P0, OWN_P1} owner_e;

  // Any shift amount at or beyond the word width clears the result.
  function automatic logic [DATA_W-1:0] srl_f(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    if (|b[DATA_W-1:SHAMT_W]) return '0;
    return a >> b[SHAMT_W-1:0];
  endfunction

endpackage

// File: rtl/srl_core.sv
// Combinational logical shift right with all-bits-lost flag.
// Optional sticky output (OR of shifted-out bits) when SRL_STICKY_EN is defined.
module srl_core #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] data,
  output logic              flag
`ifdef SRL_STICKY_EN
  ,
  output logic              sticky
`endif
);

  localparam int SH_W = $clog2(DATA_W);

  logic over;

  assign over = |b[DATA_W-1:SH_W];
  assign data = over ? '0 : (a >> b[SH_W-1:0]);
  assign flag = (a != '0) && (data == '0);

`ifdef SRL_STICKY_EN
  logic [DATA_W-1:0] lost_mask;

  // Mask of the low b bits, i.e. the ones that fall off the right end.
  assign lost_mask = ~({DATA_W{1'b1}} << b[SH_W-1:0]);
  assign sticky    = over ? (a != '0) : (|(a & lost_mask));
`endif

endmodule

// File: rtl/srl_share_ctrl.sv
// Two-port arbiter sharing one srl_core, with a 1-entry registered response slot.
// SRL_STICKY_EN adds rsp0_sticky/rsp1_sticky outputs for fadd rounding.
module srl_share_ctrl #(
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 4,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [TAG_W-1:0]  req0_tag,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp0_flag,
  output logic [TAG_W-1:0]  rsp0_tag,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              rsp1_flag,
  output logic [TAG_W-1:0]  rsp1_tag,
`ifdef SRL_STICKY_EN
  output logic              rsp0_sticky,
  output logic              rsp1_sticky,
`endif
  output logic              busy,
  output logic [15:0]       conflict_cnt
);

  import srl_pkg::*;

  slot_e             state_q, state_d;
  owner_e            owner_q;
  logic [DATA_W-1:0] data_q;
  logic              flag_q;
  logic [TAG_W-1:0]  tag_q;
  logic              rr_ptr;

  logic              sel1, gnt0, gnt1, drain, slot_free, accept;
  logic [DATA_W-1:0] mux_a, mux_b, core_data;
  logic [TAG_W-1:0]  mux_tag;
  logic              core_flag;

  assign busy       = (state_q == SLOT_FULL);
  assign rsp0_valid = busy && (owner_q == OWN_P0);
  assign rsp1_valid = busy && (owner_q == OWN_P1);
  assign drain      = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
  assign slot_free  = !busy || drain;

  assign sel1       = FIXED_PRIO ? 1'b1 : rr_ptr;
  assign gnt1       = req1_valid && (!req0_valid || sel1);
  assign gnt0       = req0_valid && !gnt1;
  assign req0_ready = gnt0 && slot_free;
  assign req1_ready = gnt1 && slot_free;
  assign accept     = req0_ready || req1_ready;

  assign mux_a   = gnt1 ? req1_a   : req0_a;
  assign mux_b   = gnt1 ? req1_b   : req0_b;
  assign mux_tag = gnt1 ? req1_tag : req0_tag;

`ifdef SRL_STICKY_EN
  logic core_sticky, sticky_q;
  srl_core #(.DATA_W(DATA_W)) u_core (
    .a(mux_a), .b(mux_b), .data(core_data), .flag(core_flag), .sticky(core_sticky)
  );
  assign rsp0_sticky = sticky_q;
  assign rsp1_sticky = sticky_q;
`else
  srl_core #(.DATA_W(DATA_W)) u_core (
    .a(mux_a), .b(mux_b), .data(core_data), .flag(core_flag)
  );
`endif

  assign rsp0_data = data_q;
  assign rsp1_data = data_q;
  assign rsp0_flag = flag_q;
  assign rsp1_flag = flag_q;
  assign rsp0_tag  = tag_q;
  assign rsp1_tag  = tag_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      SLOT_EMPTY: if (accept) state_d = SLOT_FULL;
      SLOT_FULL:  if (drain && !accept) state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= SLOT_EMPTY;
    else       state_q <= state_d;
  end

  // Slot payload is cleared on reset so the response buses read zero when idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_q  <= OWN_P0;
      data_q   <= '0;
      flag_q   <= 1'b0;
      tag_q    <= '0;
`ifdef SRL_STICKY_EN
      sticky_q <= 1'b0;
`endif
    end else if (accept) begin
      owner_q  <= gnt1 ? OWN_P1 : OWN_P0;
      data_q   <= core_data;
      flag_q   <= core_flag;
      tag_q    <= mux_tag;
`ifdef SRL_STICKY_EN
      sticky_q <= core_sticky;
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr       <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      if (accept) rr_ptr <= !gnt1;
      if (req0_valid && req1_valid && (conflict_cnt != 16'hFFFF))
        conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_srl_share_ctrl.sv
// Self-checking bench for srl_share_ctrl: directed table, corner sequences, random vs. model.
// Honours SRL_STICKY_EN when defined.
module tb_srl_share_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_tag, req1_tag;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_data, rsp1_data;
  logic        rsp0_flag, rsp1_flag;
  logic [3:0]  rsp0_tag, rsp1_tag;
  logic        busy;
  logic [15:0] conflict_cnt;
`ifdef SRL_STICKY_EN
  logic        rsp0_sticky, rsp1_sticky;
`endif

  always #5 clock = ~clock;

  srl_share_ctrl #(.DATA_W(32), .TAG_W(4), .FIXED_PRIO(1'b0)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_tag(req1_tag),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp0_flag(rsp0_flag), .rsp0_tag(rsp0_tag),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .rsp1_flag(rsp1_flag), .rsp1_tag(rsp1_tag),
`ifdef SRL_STICKY_EN
    .rsp0_sticky(rsp0_sticky), .rsp1_sticky(rsp1_sticky),
`endif
    .busy(busy), .conflict_cnt(conflict_cnt)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference rules written directly from the arithmetic definition.
  function automatic logic [31:0] m_data(input logic [31:0] a, input logic [31:0] b);
    if (b > 32'd31) return 32'd0;
    return a >> b;
  endfunction
  function automatic logic m_flag(input logic [31:0] a, input logic [31:0] b);
    return (a != 0) && (m_data(a, b) == 0);
  endfunction
  function automatic logic m_sticky(input logic [31:0] a, input logic [31:0] b);
    longint unsigned full, modv;
    if (b > 32'd31) return a != 0;
    full = 64'(a);
    modv = 64'd1 << b;
    return (full % modv) != 0;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req0_tag = 0;
    req1_a = 0; req1_b = 0; req1_tag = 0;
    rsp0_ready = 1; rsp1_ready = 1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_cnt", 64'(conflict_cnt), 0);
    tick();
  endtask

  typedef struct {
    logic        port;
    logic [31:0] a, b;
    logic [3:0]  tag;
    logic [31:0] e_data;
    logic        e_flag, e_sticky;
  } vec_t;
  vec_t tbl[10];

  // Random-phase model state
  typedef struct {
    int          port;
    logic [31:0] data;
    logic        flag, sticky;
    logic [3:0]  tag;
  } rsp_t;
  rsp_t        pend[$];
  int          last_win, m_cnt;
  logic        hold0, hold1, v0, v1, e_r0, e_r1, drn;
  int          win;
  rsp_t        nr;

  function automatic logic [31:0] rand_a();
    case ($urandom % 4)
      0: return 32'd0;
      1: return 32'd1 << ($urandom % 32);
      default: return $urandom;
    endcase
  endfunction
  function automatic logic [31:0] rand_b();
    case ($urandom % 4)
      0: return 32'($urandom % 32);
      1: return 32'(32 + $urandom % 10);
      2: return $urandom;
      default: return 32'($urandom % 8);
    endcase
  endfunction

  initial begin
    tbl[0] = '{1'b0, 32'hF000_0000, 32'd4,  4'h3, 32'h0F00_0000, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 32'hDEAD_BEEF, 32'd0,  4'h5, 32'hDEAD_BEEF, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 32'h8000_0000, 32'd31, 4'h6, 32'h0000_0001, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 32'h0000_0005, 32'd32, 4'h7, 32'h0000_0000, 1'b1, 1'b1};
    tbl[4] = '{1'b1, 32'h0000_0000, 32'd40, 4'h8, 32'h0000_0000, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 32'h0000_0013, 32'd2,  4'h9, 32'h0000_0004, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 32'h0000_0010, 32'd4,  4'hA, 32'h0000_0001, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 32'hFFFF_FFFF, 32'h0001_0003, 4'hB, 32'h0, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 32'h0000_0001, 32'd1,  4'hC, 32'h0000_0000, 1'b1, 1'b1};
    tbl[9] = '{1'b1, 32'h1234_5678, 32'd8,  4'hD, 32'h0012_3456, 1'b0, 1'b1};

    idle();
    reset = 1'b1;
    #3;
    chk("reset_busy", 64'(busy), 0);
    chk("reset_rsp0_valid", 64'(rsp0_valid), 0);
    chk("reset_rsp1_valid", 64'(rsp1_valid), 0);
    chk("reset_data", 64'(rsp0_data), 0);
    chk("reset_cnt", 64'(conflict_cnt), 0);
    @(negedge clock);
    reset = 1'b0;
    tick();

    // Directed table, one requester at a time
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].port == 1'b0) begin
        req0_valid = 1; req0_a = tbl[i].a; req0_b = tbl[i].b; req0_tag = tbl[i].tag;
      end else begin
        req1_valid = 1; req1_a = tbl[i].a; req1_b = tbl[i].b; req1_tag = tbl[i].tag;
      end
      #1;
      chk($sformatf("tbl%0d_ready", i), 64'(tbl[i].port ? req1_ready : req0_ready), 1);
      tick();
      req0_valid = 0; req1_valid = 0;
      #1;
      chk($sformatf("tbl%0d_v0", i), 64'(rsp0_valid), 64'(!tbl[i].port));
      chk($sformatf("tbl%0d_v1", i), 64'(rsp1_valid), 64'(tbl[i].port));
      chk($sformatf("tbl%0d_data", i), 64'(tbl[i].port ? rsp1_data : rsp0_data), 64'(tbl[i].e_data));
      chk($sformatf("tbl%0d_flag", i), 64'(tbl[i].port ? rsp1_flag : rsp0_flag), 64'(tbl[i].e_flag));
      chk($sformatf("tbl%0d_tag", i), 64'(tbl[i].port ? rsp1_tag : rsp0_tag), 64'(tbl[i].tag));
`ifdef SRL_STICKY_EN
      chk($sformatf("tbl%0d_sticky", i), 64'(tbl[i].port ? rsp1_sticky : rsp0_sticky),
          64'(tbl[i].e_sticky));
`endif
      tick();
      chk($sformatf("tbl%0d_drained", i), 64'(busy), 0);
    end

    // Collision: four back-to-back grants alternate starting with port 0
    do_reset();
    req0_valid = 1; req0_a = 32'h0000_0100; req0_b = 32'd4; req0_tag = 4'h1;
    req1_valid = 1; req1_a = 32'h0000_0F00; req1_b = 32'd8; req1_tag = 4'h2;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("coll%0d_r0", k), 64'(req0_ready), 64'(k % 2 == 0));
      chk($sformatf("coll%0d_r1", k), 64'(req1_ready), 64'(k % 2 == 1));
      if (k > 0) chk($sformatf("coll%0d_prev", k), 64'(k % 2 == 0 ? rsp1_valid : rsp0_valid), 1);
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    #1;
    chk("coll_cnt", 64'(conflict_cnt), 4);
    chk("coll_last_v1", 64'(rsp1_valid), 1);
    chk("coll_last_data", 64'(rsp1_data), 32'h0000_000F);
    tick();

    // Back-pressure on port 1, then drain and refill in the same cycle
    do_reset();
    rsp1_ready = 0;
    req1_valid = 1; req1_a = 32'h0000_00F0; req1_b = 32'd4; req1_tag = 4'h1;
    #1;
    chk("bp_first_ready", 64'(req1_ready), 1);
    tick();
    req0_valid = 1; req0_a = 32'h0000_0100; req0_b = 32'd0; req0_tag = 4'h2;
    req1_a = 32'h0000_0002; req1_tag = 4'h3;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d_r0", k), 64'(req0_ready), 0);
      chk($sformatf("bp%0d_r1", k), 64'(req1_ready), 0);
      chk($sformatf("bp%0d_v1", k), 64'(rsp1_valid), 1);
      chk($sformatf("bp%0d_data", k), 64'(rsp1_data), 32'h0000_000F);
      tick();
    end
    rsp1_ready = 1;
    #1;
    chk("bp_rel_r0", 64'(req0_ready), 1);
    chk("bp_rel_r1", 64'(req1_ready), 0);
    tick();
    req0_valid = 0; req1_valid = 0;
    #1;
    chk("bp_next_v0", 64'(rsp0_valid), 1);
    chk("bp_next_v1", 64'(rsp1_valid), 0);
    chk("bp_next_data", 64'(rsp0_data), 32'h0000_0100);
    tick();

    // Asynchronous reset while a response is held
    do_reset();
    rsp0_ready = 0;
    req0_valid = 1; req0_a = 32'h0000_00FF; req0_b = 32'd1; req0_tag = 4'h4;
    req1_valid = 1; req1_a = 32'h0000_0001; req1_b = 32'd0; req1_tag = 4'h5;
    tick();
    req0_valid = 0; req1_valid = 0;
    #1;
    chk("mid_v0_before", 64'(rsp0_valid), 1);
    chk("mid_cnt_before", 64'(conflict_cnt), 1);
    reset = 1'b1;
    #1;
    chk("mid_v0", 64'(rsp0_valid), 0);
    chk("mid_v1", 64'(rsp1_valid), 0);
    chk("mid_busy", 64'(busy), 0);
    chk("mid_cnt", 64'(conflict_cnt), 0);
    chk("mid_data", 64'(rsp0_data), 0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("mid_after%0d", k), 64'({rsp0_valid, rsp1_valid, busy}), 0);
    end
    rsp0_ready = 1;

    // Randomized traffic against the transaction-level model
    do_reset();
    pend.delete();
    last_win = 1;
    m_cnt = 0;
    hold0 = 0; hold1 = 0;
    for (int c = 0; c < 1500; c++) begin
      if (!hold0) begin
        req0_valid = ($urandom % 10) < 6;
        req0_a = rand_a(); req0_b = rand_b(); req0_tag = 4'($urandom);
      end
      if (!hold1) begin
        req1_valid = ($urandom % 10) < 6;
        req1_a = rand_a(); req1_b = rand_b(); req1_tag = 4'($urandom);
      end
      rsp0_ready = ($urandom % 4) != 0;
      rsp1_ready = ($urandom % 4) != 0;
      v0 = req0_valid; v1 = req1_valid;
      #1;
      chk("rnd_busy", 64'(busy), 64'(pend.size() != 0));
      chk("rnd_v0", 64'(rsp0_valid), 64'(pend.size() != 0 && pend[0].port == 0));
      chk("rnd_v1", 64'(rsp1_valid), 64'(pend.size() != 0 && pend[0].port == 1));
      if (pend.size() != 0) begin
        chk("rnd_data", 64'(pend[0].port ? rsp1_data : rsp0_data), 64'(pend[0].data));
        chk("rnd_flag", 64'(pend[0].port ? rsp1_flag : rsp0_flag), 64'(pend[0].flag));
        chk("rnd_tag", 64'(pend[0].port ? rsp1_tag : rsp0_tag), 64'(pend[0].tag));
`ifdef SRL_STICKY_EN
        chk("rnd_sticky", 64'(pend[0].port ? rsp1_sticky : rsp0_sticky), 64'(pend[0].sticky));
`endif
      end
      chk("rnd_cnt", 64'(conflict_cnt), 64'(m_cnt));
      drn = pend.size() != 0 && (pend[0].port ? rsp1_ready : rsp0_ready);
      win = -1;
      if (v0 && v1) win = (last_win == 0) ? 1 : 0;
      else if (v0)  win = 0;
      else if (v1)  win = 1;
      if (pend.size() != 0 && !drn) win = -1;
      e_r0 = (win == 0);
      e_r1 = (win == 1);
      chk("rnd_r0", 64'(req0_ready), 64'(e_r0));
      chk("rnd_r1", 64'(req1_ready), 64'(e_r1));
      if (drn) void'(pend.pop_front());
      if (win >= 0) begin
        nr.port   = win;
        nr.data   = m_data(win ? req1_a : req0_a, win ? req1_b : req0_b);
        nr.flag   = m_flag(win ? req1_a : req0_a, win ? req1_b : req0_b);
        nr.sticky = m_sticky(win ? req1_a : req0_a, win ? req1_b : req0_b);
        nr.tag    = win ? req1_tag : req0_tag;
        pend.push_back(nr);
        last_win = win;
      end
      if (v0 && v1 && m_cnt < 65535) m_cnt++;
      hold0 = v0 && !e_r0;
      hold1 = v1 && !e_r1;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
